cic_decimator_mc: RTL

Multi-channel, runtime-rate CIC decimator, the parametrised successor of the single-channel fixed-rate CIC filter. It runs CHANNELS parallel lanes that share one sample strobe and one decimation phase. Rate is a power of two selected at run time, differential delay is 1, and the gain is exactly normalised by a shift. It sits between the fast-clock sample source and any slow-rate consumer, with a valid-qualified input and a valid-pulsed output.

---
 rtl/cic_decimator_mc_if.sv | 29 ++
 rtl/cic_decimator_mc.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cic_decimator_mc_if.sv
// Sample-stream bundle for cic_decimator_mc.
//   in_valid  : sample strobe shared by all channels
//   in_data   : CHANNELS packed IN_WIDTH-bit samples, channel c at [c*IN_WIDTH +: IN_WIDTH]
//   out_valid : one-cycle pulse marking a decimated output
//   out_data  : decimated outputs, same packing as in_data
// master drives samples and receives outputs; slave is the decimator side.
interface cic_decimator_mc_if #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned CHANNELS = 2
);
  logic                         in_valid;
  logic [CHANNELS*IN_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic [CHANNELS*IN_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator with run-time power-of-two rate (R = 2^rate_r),
// differential delay 1, and exact gain normalisation by a right shift of STAGES*rate_r.
// Ports:
//   fast_clk  : clock, rising edge
//   rstn      : asynchronous active-low reset
//   clear     : synchronous clear of all datapath state; re-latches rate_log2
//   rate_log2 : log2 of decimation ratio, saturated to $clog2(MAX_RATE)
//   bus       : slave side of cic_decimator_mc_if (in_valid/in_data, out_valid/out_data)
module cic_decimator_mc #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned MAX_RATE = 16,
  parameter int unsigned CHANNELS = 2
) (
  input  logic                       fast_clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic [$clog2(MAX_RATE):0]  rate_log2,
  cic_decimator_mc_if.slave          bus
);
  localparam int unsigned LogMax = $clog2(MAX_RATE);
  localparam int unsigned RateW  = LogMax + 1;
  localparam int unsigned AccW   = IN_WIDTH + STAGES * LogMax;
  localparam int unsigned DataW  = CHANNELS * IN_WIDTH;

  logic [RateW-1:0]  rate_q, rate_sat, rate_eff;
  logic              started_q;
  logic [LogMax-1:0] phase_q, phase_d;
  logic              accept, phase_last, strobe;
  logic [STAGES:0]   stb_q, stb_d;
  logic              out_valid_q, out_valid_d;
  logic [DataW-1:0]  out_data_q, out_data_d;

  logic [AccW-1:0] integ_q  [CHANNELS][STAGES];
  logic [AccW-1:0] integ_d  [CHANNELS][STAGES];
  logic [AccW-1:0] dly_q    [CHANNELS][STAGES];
  logic [AccW-1:0] dly_d    [CHANNELS][STAGES];
  logic [AccW-1:0] comb_q   [CHANNELS][STAGES];
  logic [AccW-1:0] comb_d   [CHANNELS][STAGES];
  logic [AccW-1:0] comb_src [CHANNELS][STAGES];

  always_comb begin
    rate_sat = (rate_log2 > RateW'(LogMax)) ? RateW'(LogMax) : rate_log2;
    // On the first cycle after reset rate_q is not latched yet; use the incoming value so a
    // sample accepted in that cycle already counts against the right ratio.
    rate_eff   = started_q ? rate_q : rate_sat;
    accept     = bus.in_valid & ~clear;
    phase_last = ({1'b0, phase_q} == ((RateW'(1) << rate_eff) - RateW'(1)));
    strobe     = accept & phase_last;
  end

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (accept) begin
      phase_d = phase_last ? '0 : phase_q + LogMax'(1);
    end
  end

  // Comb stage 0 differentiates the last integrator; later stages chain off the previous comb.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      comb_src[c][0] = integ_q[c][STAGES-1];
      for (int k = 1; k < STAGES; k++) begin
        comb_src[c][k] = comb_q[c][k-1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[c][k] = integ_q[c][k];
        dly_d[c][k]   = dly_q[c][k];
        comb_d[c][k]  = comb_q[c][k];
      end
      if (accept) begin
        integ_d[c][0] = integ_q[c][0] + AccW'(bus.in_data[c*IN_WIDTH +: IN_WIDTH]);
        // Pre-edge value of the previous stage: a pipelined integrator chain.
        for (int k = 1; k < STAGES; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
      for (int k = 0; k < STAGES; k++) begin
        if (stb_q[k]) begin
          comb_d[c][k] = comb_src[c][k] - dly_q[c][k];
          dly_d[c][k]  = comb_src[c][k];
        end
      end
      if (clear) begin
        for (int k = 0; k < STAGES; k++) begin
          integ_d[c][k] = '0;
          dly_d[c][k]   = '0;
          comb_d[c][k]  = '0;
        end
      end
    end
  end

  always_comb begin
    stb_d       = clear ? '0 : {stb_q[STAGES-1:0], strobe};
    out_valid_d = stb_q[STAGES] & ~clear;
    out_data_d  = out_data_q;
    if (clear) begin
      out_data_d = '0;
    end else if (stb_q[STAGES]) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_data_d[c*IN_WIDTH +: IN_WIDTH] =
          IN_WIDTH'(comb_q[c][STAGES-1] >> (STAGES * rate_q));
      end
    end
  end

  always_ff @(posedge fast_clk or negedge rstn) begin
    if (!rstn) begin
      rate_q      <= '0;
      started_q   <= 1'b0;
      phase_q     <= '0;
      stb_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          integ_q[c][k] <= '0;
          dly_q[c][k]   <= '0;
          comb_q[c][k]  <= '0;
        end
      end
    end else begin
      if (!started_q || clear) begin
        rate_q <= rate_sat;
      end
      started_q   <= 1'b1;
      phase_q     <= phase_d;
      stb_q       <= stb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          integ_q[c][k] <= integ_d[c][k];
          dly_q[c][k]   <= dly_d[c][k];
          comb_q[c][k]  <= comb_d[c][k];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
